btn_cond: RTL and testbench



---
 rtl/btn_cond.sv | 156 +++++++++++++++
 tb/tb_btn_cond.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/btn_cond.sv
// Push-button conditioner: sync, debounce, press/release/long/repeat strobes.
// Optional macro BTN_REPEAT_EN enables periodic auto-repeat in the long state.
module btn_cond #(
  parameter int unsigned N_SW          = 4,
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_level,
  output logic [N_SW-1:0] o_press,
  output logic [N_SW-1:0] o_release,
  output logic [N_SW-1:0] o_long,
  output logic [N_SW-1:0] o_rpt
);

  typedef enum logic [1:0] {IDLE, DOWN, LONG} st_e;

  st_e             state_q [N_SW];
  st_e             state_d [N_SW];
  logic [31:0]     db_q    [N_SW];
  logic [31:0]     db_d    [N_SW];
  logic [31:0]     hold_q  [N_SW];
  logic [31:0]     hold_d  [N_SW];
`ifdef BTN_REPEAT_EN
  logic [31:0]     rcnt_q  [N_SW];
  logic [31:0]     rcnt_d  [N_SW];
`endif
  logic [N_SW-1:0] s1_q, s2_q;
  logic [N_SW-1:0] level_q, level_d;
  logic [N_SW-1:0] press_q, press_d;
  logic [N_SW-1:0] rel_q, rel_d;
  logic [N_SW-1:0] long_q, long_d;
  logic [N_SW-1:0] rpt_q, rpt_d;
  logic [N_SW-1:0] acc, rise, fall;

  // A level change is accepted on the edge its stable count completes.
  always_comb begin
    for (int i = 0; i < int'(N_SW); i++) begin
      acc[i] = (s2_q[i] != level_q[i]) && (db_q[i] == DB_CYCLES - 1);
    end
  end

  assign rise = acc & s2_q;
  assign fall = acc & ~s2_q;

  always_comb begin
    level_d = level_q ^ acc;
    press_d = '0;
    rel_d   = '0;
    long_d  = long_q;
    rpt_d   = '0;
    for (int i = 0; i < int'(N_SW); i++) begin
      state_d[i] = state_q[i];
      hold_d[i]  = hold_q[i];
`ifdef BTN_REPEAT_EN
      rcnt_d[i]  = rcnt_q[i];
`endif
      if ((s2_q[i] != level_q[i]) && !acc[i]) begin
        db_d[i] = db_q[i] + 32'd1;
      end else begin
        db_d[i] = '0;
      end
      unique case (state_q[i])
        IDLE: begin
          if (rise[i]) begin
            press_d[i] = 1'b1;
            hold_d[i]  = '0;
            state_d[i] = DOWN;
          end
        end
        DOWN: begin
          if (fall[i]) begin
            rel_d[i]   = 1'b1;
            long_d[i]  = 1'b0;
            hold_d[i]  = '0;
            state_d[i] = IDLE;
          end else if (hold_q[i] == LONG_CYCLES - 1) begin
            long_d[i]  = 1'b1;
            rpt_d[i]   = 1'b1;
`ifdef BTN_REPEAT_EN
            rcnt_d[i]  = '0;
`endif
            state_d[i] = LONG;
          end else begin
            hold_d[i] = hold_q[i] + 32'd1;
          end
        end
        LONG: begin
          if (fall[i]) begin
            rel_d[i]   = 1'b1;
            long_d[i]  = 1'b0;
            hold_d[i]  = '0;
`ifdef BTN_REPEAT_EN
            rcnt_d[i]  = '0;
`endif
            state_d[i] = IDLE;
`ifdef BTN_REPEAT_EN
          end else if (rcnt_q[i] == REPEAT_CYCLES - 1) begin
            rpt_d[i]  = 1'b1;
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + 32'd1;
`endif
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      rpt_q   <= '0;
      for (int i = 0; i < int'(N_SW); i++) begin
        state_q[i] <= IDLE;
        db_q[i]    <= '0;
        hold_q[i]  <= '0;
`ifdef BTN_REPEAT_EN
        rcnt_q[i]  <= '0;
`endif
      end
    end else begin
      s1_q    <= i_sw;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      for (int i = 0; i < int'(N_SW); i++) begin
        state_q[i] <= state_d[i];
        db_q[i]    <= db_d[i];
        hold_q[i]  <= hold_d[i];
`ifdef BTN_REPEAT_EN
        rcnt_q[i]  <= rcnt_d[i];
`endif
      end
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = rel_q;
  assign o_long    = long_q;
  assign o_rpt     = rpt_q;

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond with DB=4, LONG=20, REPEAT=5.
module tb_btn_cond;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] i_sw = '0;
  logic [3:0] o_level, o_press, o_release, o_long, o_rpt;

  int n_cmp = 0;
  int n_bad = 0;

  btn_cond #(
    .N_SW(4), .DB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_sw(i_sw),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_long(o_long), .o_rpt(o_rpt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_sw  = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_level, o_press, o_release, o_long, o_rpt} !== 20'h0) begin
      n_bad++;
      $display("FAIL reset: outputs %h, required 0",
               {o_level, o_press, o_release, o_long, o_rpt});
    end
  endtask

  task automatic test_press();
    do_reset();
    i_sw = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (o_level !== ((k >= 6) ? 4'b0001 : 4'b0000) ||
          o_press !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL press edge %0d: level=%b press=%b", k, o_level, o_press);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      i_sw[1] = (k <= 8) ? (((k - 1) / 2) % 2 == 0) : 1'b0;
      tick();
      n_cmp++;
      if (o_level[1] !== 1'b0 || o_press[1] !== 1'b0 ||
          o_release[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL bounce edge %0d: level=%b press=%b rel=%b required 0",
                 k, o_level[1], o_press[1], o_release[1]);
      end
    end
  endtask

  // Channel 2 held until edge drop-1; drop=0 means held throughout.
  task automatic run_ch2(input string nm, input int drop, input int last);
    int fe;
    logic el, ep, er, eg, et;
    fe = (drop == 0) ? 1000 : drop + 5;
    do_reset();
    for (int k = 1; k <= last; k++) begin
      i_sw[2] = (drop == 0) || (k < drop);
      tick();
      el = (k >= 6) && (k < fe);
      ep = (k == 6);
      er = (k == fe);
      eg = (k >= 26) && (k < fe);
`ifdef BTN_REPEAT_EN
      et = (k < fe) && (k >= 26) && ((k - 26) % 5 == 0);
`else
      et = (k == 26) && (k < fe);
`endif
      n_cmp++;
      if (o_level[2] !== el || o_press[2] !== ep || o_release[2] !== er ||
          o_long[2] !== eg || o_rpt[2] !== et) begin
        n_bad++;
        $display("FAIL %s edge %0d: lv/pr/rl/lg/rp=%b%b%b%b%b required %b%b%b%b%b",
                 nm, k, o_level[2], o_press[2], o_release[2], o_long[2],
                 o_rpt[2], el, ep, er, eg, et);
      end
      n_cmp++;
      if ({o_level[3], o_level[1:0], o_press[3], o_press[1:0]} !== 6'b0) begin
        n_bad++;
        $display("FAIL %s edge %0d: other channels level=%b press=%b",
                 nm, k, o_level, o_press);
      end
    end
  endtask

  task automatic test_long_repeat();
    run_ch2("long_repeat", 0, 45);
  endtask

  task automatic test_release();
    run_ch2("release", 28, 45);
  endtask

  task automatic test_same_edge_release();
    run_ch2("same_edge", 31, 42);
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    i_sw = 4'b1000;
    repeat (30) tick();
    n_cmp++;
    if (o_long[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_hold_long: o_long[3]=%b required 1", o_long[3]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_level, o_press, o_release, o_long, o_rpt} !== 20'h0) begin
      n_bad++;
      $display("FAIL mid_hold_async: outputs %h required 0",
               {o_level, o_press, o_release, o_long, o_rpt});
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if ({o_level, o_press, o_release, o_long, o_rpt} !== 20'h0) begin
        n_bad++;
        $display("FAIL mid_hold_in_reset %0d: outputs %h required 0", k,
                 {o_level, o_press, o_release, o_long, o_rpt});
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_cmp++;
      if (o_press !== ((k == 6) ? 4'b1000 : 4'b0000) ||
          o_level !== ((k >= 6) ? 4'b1000 : 4'b0000)) begin
        n_bad++;
        $display("FAIL after_reset edge %0d: press=%b level=%b", k,
                 o_press, o_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_long_repeat();
    test_release();
    test_same_edge_release();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
